sram_arbiter: RTL and testbench
===============================

# sram_arbiter

Shares the single off-chip SRAM between the CPU memory path (MemoryControlUnit) and the video text-buffer fetcher, and sequences each SRAM access as a fixed multi-cycle read or write. It sits between both requesters and the SRAM pins. Its chip-select, output-enable, write-enable and byte-lane strobes replace the per-signal synchronizers currently on the top level.

## Interface
- ACCESS_CYCLES, 2, number of cycles CE_N/OE_N (or WE_N) are held active in the ACCESS state; legal range 1..15
- Clk  in  1  system clock (CLOCK_50)
- Reset_N  in  1  asynchronous, active-low reset; one clock domain only
- CPU_Req  in  1  CPU access request, level, held until CPU_Ack
- CPU_WE  in  1  1 = write, 0 = read; sampled with request
- CPU_Addr  in  16  CPU word address
- CPU_WData  in  16  CPU write data
- CPU_RData  out  16  registered read data, valid while CPU_Ack=1
- CPU_Ack  out  1  one-cycle completion pulse
- VID_Req  in  1  video read request, level, held until VID_Ack
- VID_Addr  in  16  video word address
- VID_RData  out  16  registered read data, valid while VID_Ack=1
- VID_Ack  out  1  one-cycle completion pulse
- Grant  out  1  owner of the current transaction: 0 = CPU, 1 = video
- Busy  out  1  high in every state except IDLE
- SRAM_ADDR  out  20  {4'b0000, latched address}
- SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_LB_N, SRAM_UB_N  out  1 each  active-low SRAM strobes, all registered
- SRAM_WData  out  16  write data to the bidirectional tristate
- SRAM_DriveEn  out  1  enables the tristate to drive SRAM_DQ
- SRAM_RData  in  16  data from the tristate

## Operation
- States: IDLE → SETUP → ACCESS (ACCESS_CYCLES cycles, counted down by a 4-bit counter) → DONE → IDLE.
- IDLE: if either request is high, arbitrate, then latch owner, address, WE, and write data. Owner is CPU if only CPU_Req is high, and video if only VID_Req is high. For simultaneous requests, see Configuration.
- Video is read-only, so WE is forced to 0 for video grants.
- SETUP: SRAM_ADDR valid, CE_N=0, LB_N=UB_N=0. For writes, DriveEn=1. For reads, OE_N=0.
- ACCESS: reads keep OE_N=0. Writes drive WE_N=0 only in this state. SRAM_RData is captured into the owner's RData register on the last ACCESS cycle.
- DONE: strobes deasserted (all 1). The owner's Ack is 1 and the other Ack is 0. DriveEn stays 1 for writes as a hold cycle, and SRAM_ADDR stays stable.
- Request/write data changes after latching are ignored. Deasserting a request mid-transaction does not abort it; the write still completes and Ack still pulses.
- The non-owner RData register holds its previous value.

## Timing
- Reset values (async, immediate): state IDLE, all SRAM strobes 1, DriveEn 0, SRAM_ADDR 0, SRAM_WData 0, both RData 0, both Ack 0, Grant 0, Busy 0, round-robin pointer = video (CPU wins the first tie).
- Reset asserted mid-transaction returns to IDLE at once. No Ack is generated, and the access is lost.
- Latency: request seen high at IDLE edge t. SETUP is at t+1, ACCESS spans t+2..t+1+ACCESS_CYCLES, and Ack is at t+2+ACCESS_CYCLES. With the default value, Ack arrives 4 cycles after acceptance.
- Handshake: a requester must drop its request in the cycle following Ack. If it is still high at the next IDLE edge, a new transaction (back-to-back) starts.
- Minimum spacing between two transactions is ACCESS_CYCLES+3 cycles (one IDLE cycle always intervenes).
- WE_N is never low in SETUP or DONE. Address and data are stable one cycle before and after WE_N low.

## Configuration
- ELC3_SRAM_RR_EN defined: simultaneous requests alternate. A 1-bit pointer records the last owner and is updated when each transaction is accepted. The requester that did not win last time is granted.
- Not defined: fixed priority, CPU always wins ties. Video can starve under continuous CPU traffic. The pointer register is not built.

## Structure
- elc3_pkg holds `sram_arb_state_t` (IDLE, SETUP, ACCESS, DONE), the requester encoding constants (REQ_CPU=0, REQ_VID=1), and the SRAM address-pad width constant (20).
- One sub-module, arb2_select: combinational tie-break plus the round-robin pointer flop (pointer present only under ELC3_SRAM_RR_EN). It outputs the winning requester.

## Test plan
- CPU read at 0x3000 (SRAM model returns 0xBEEF), ACCESS_CYCLES=2 → OE_N low for 3 cycles, CPU_Ack pulse 4 cycles after acceptance, CPU_RData=0xBEEF, VID_Ack stays 0.
- CPU write 0xA5A5 to 0xFE00 → WE_N low for exactly 2 cycles, DriveEn high for 4 cycles (SETUP..DONE), SRAM_ADDR=0x0FE00 throughout, read-back returns 0xA5A5.
- CPU and video requests in the same cycle, held continuously (Ack-acknowledged), macro defined → grants CPU, VID, CPU, VID. Macro undefined → CPU every time, VID_Ack never asserted.
- Video read at 0x8000 while CPU_Req rises during its ACCESS → video completes first (VID_Ack), then CPU is granted after one IDLE cycle.
- Reset_N pulsed low during ACCESS of a write → strobes return to 1 and DriveEn to 0 immediately. No Ack. IDLE after release, and the next request is serviced normally.
- CPU_Req dropped during SETUP of a read → transaction completes, CPU_Ack still pulses once, and no second transaction starts.

Source files
------------

// File: rtl/elc3_pkg.sv
// ---------------------------------------------------------------------------
// elc3_pkg
// Shared types and constants for the SRAM arbiter slice.
//   sram_arb_state_t : access sequencer states (IDLE, SETUP, ACCESS, DONE)
//   REQ_CPU / REQ_VID: requester encoding used for Grant and the tie-break
//   SRAM_ADDR_W      : width of the SRAM address pads
// ---------------------------------------------------------------------------
package elc3_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } sram_arb_state_t;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_VID = 1'b1;

    localparam int SRAM_ADDR_W = 20;

endpackage

// File: rtl/arb2_select.sv
// ---------------------------------------------------------------------------
// arb2_select
// Two-requester tie-break for the SRAM arbiter.
//   clk, rst_n : clock and asynchronous active-low reset (pointer flop only)
//   cpu_req    : CPU request level
//   vid_req    : video request level
//   accept     : a transaction is being accepted this cycle
//   winner     : REQ_CPU or REQ_VID, the requester to grant
// Optional feature macro: ELC3_SRAM_RR_EN
//   defined   -> simultaneous requests alternate; a 1-bit pointer remembers
//                the last owner and the other side wins the next tie.
//   undefined -> fixed priority, CPU always wins a tie; no pointer flop.
// ---------------------------------------------------------------------------
module arb2_select
    import elc3_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic cpu_req,
    input  logic vid_req,
    input  logic accept,
    output logic winner
);

`ifdef ELC3_SRAM_RR_EN
    logic last_reg;

    // Reset to video so the very first tie goes to the CPU.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_reg <= REQ_VID;
        end else if (accept) begin
            last_reg <= winner;
        end
    end

    always_comb begin
        winner = REQ_CPU;
        if (cpu_req && vid_req) begin
            winner = (last_reg == REQ_CPU) ? REQ_VID : REQ_CPU;
        end else if (vid_req) begin
            winner = REQ_VID;
        end
    end
`else
    // Fixed priority has no state; keep the pointer-related inputs tied off.
    logic unused_ok;
    assign unused_ok = &{1'b0, clk, rst_n, accept};

    always_comb begin
        winner = (vid_req && !cpu_req) ? REQ_VID : REQ_CPU;
    end
`endif

endmodule

// File: rtl/sram_arbiter.sv
// ---------------------------------------------------------------------------
// sram_arbiter
// Shares the off-chip SRAM between the CPU memory path and the video text
// fetcher, and sequences every access as IDLE -> SETUP -> ACCESS (x N) ->
// DONE -> IDLE. All SRAM strobes are registered.
//   Clk, Reset_N              : clock, asynchronous active-low reset
//   CPU_Req/WE/Addr/WData     : CPU request (level, held until CPU_Ack)
//   CPU_RData, CPU_Ack        : CPU read data and one-cycle completion pulse
//   VID_Req/Addr              : video read request (level)
//   VID_RData, VID_Ack        : video read data and completion pulse
//   Grant                     : current owner (0 = CPU, 1 = video)
//   Busy                      : high in every state except IDLE
//   SRAM_ADDR                 : {4'b0000, latched word address}
//   SRAM_CE_N/OE_N/WE_N/LB_N/UB_N : active-low SRAM strobes
//   SRAM_WData, SRAM_DriveEn  : write data and tristate enable for SRAM_DQ
//   SRAM_RData                : data returned from the tristate
// Parameter ACCESS_CYCLES (1..15): cycles spent in ACCESS.
// Optional feature macro: ELC3_SRAM_RR_EN (round-robin tie-break, see
// arb2_select); default build uses fixed CPU priority.
// ---------------------------------------------------------------------------
module sram_arbiter
    import elc3_pkg::*;
#(
    parameter int ACCESS_CYCLES = 2
)(
    input  logic                   Clk,
    input  logic                   Reset_N,
    input  logic                   CPU_Req,
    input  logic                   CPU_WE,
    input  logic [15:0]            CPU_Addr,
    input  logic [15:0]            CPU_WData,
    output logic [15:0]            CPU_RData,
    output logic                   CPU_Ack,
    input  logic                   VID_Req,
    input  logic [15:0]            VID_Addr,
    output logic [15:0]            VID_RData,
    output logic                   VID_Ack,
    output logic                   Grant,
    output logic                   Busy,
    output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    output logic                   SRAM_CE_N,
    output logic                   SRAM_OE_N,
    output logic                   SRAM_WE_N,
    output logic                   SRAM_LB_N,
    output logic                   SRAM_UB_N,
    output logic [15:0]            SRAM_WData,
    output logic                   SRAM_DriveEn,
    input  logic [15:0]            SRAM_RData
);

    localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

    sram_arb_state_t state_reg, state_next;
    logic [3:0]      cnt_reg, cnt_next;
    logic            owner_reg, owner_next;
    logic            we_reg, we_next;
    logic [15:0]     addr_reg, addr_next;
    logic [15:0]     wdata_reg, wdata_next;

    logic            ce_n_reg, ce_n_next;
    logic            oe_n_reg, oe_n_next;
    logic            we_n_reg, we_n_next;
    logic            lb_n_reg, ub_n_reg, be_n_next;
    logic            drive_reg, drive_next;
    logic            cpu_ack_reg, cpu_ack_next;
    logic            vid_ack_reg, vid_ack_next;
    logic [15:0]     cpu_rdata_reg, vid_rdata_reg;

    logic            accept;
    logic            winner;
    logic            active_next;
    logic            capture;

    arb2_select u_select (
        .clk     (Clk),
        .rst_n   (Reset_N),
        .cpu_req (CPU_Req),
        .vid_req (VID_Req),
        .accept  (accept),
        .winner  (winner)
    );

    // Next-state and transaction latch.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        owner_next = owner_reg;
        we_next    = we_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        accept     = 1'b0;

        case (state_reg)
            IDLE: begin
                if (CPU_Req || VID_Req) begin
                    accept     = 1'b1;
                    owner_next = winner;
                    state_next = SETUP;
                    if (winner == REQ_VID) begin
                        addr_next = VID_Addr;
                        we_next   = 1'b0;          // video never writes
                    end else begin
                        addr_next  = CPU_Addr;
                        we_next    = CPU_WE;
                        wdata_next = CPU_WData;
                    end
                end
            end
            SETUP: begin
                state_next = ACCESS;
                cnt_next   = CNT_LOAD;
            end
            ACCESS: begin
                if (cnt_reg == 4'd0) begin
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Strobes are decoded from the state being entered so that the
    // registered pins line up exactly with the state register.
    always_comb begin
        active_next  = (state_next == SETUP) || (state_next == ACCESS);
        ce_n_next    = !active_next;
        be_n_next    = !active_next;
        oe_n_next    = !(active_next && !we_next);
        we_n_next    = !((state_next == ACCESS) && we_next);
        // DONE keeps driving for one hold cycle after WE_N rises.
        drive_next   = we_next && (active_next || (state_next == DONE));
        cpu_ack_next = (state_next == DONE) && (owner_reg == REQ_CPU);
        vid_ack_next = (state_next == DONE) && (owner_reg == REQ_VID);
        capture      = (state_reg == ACCESS) && (cnt_reg == 4'd0) && !we_reg;
    end

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            state_reg     <= IDLE;
            cnt_reg       <= 4'd0;
            owner_reg     <= REQ_CPU;
            we_reg        <= 1'b0;
            addr_reg      <= 16'd0;
            wdata_reg     <= 16'd0;
            ce_n_reg      <= 1'b1;
            oe_n_reg      <= 1'b1;
            we_n_reg      <= 1'b1;
            lb_n_reg      <= 1'b1;
            ub_n_reg      <= 1'b1;
            drive_reg     <= 1'b0;
            cpu_ack_reg   <= 1'b0;
            vid_ack_reg   <= 1'b0;
            cpu_rdata_reg <= 16'd0;
            vid_rdata_reg <= 16'd0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            owner_reg   <= owner_next;
            we_reg      <= we_next;
            addr_reg    <= addr_next;
            wdata_reg   <= wdata_next;
            ce_n_reg    <= ce_n_next;
            oe_n_reg    <= oe_n_next;
            we_n_reg    <= we_n_next;
            lb_n_reg    <= be_n_next;
            ub_n_reg    <= be_n_next;
            drive_reg   <= drive_next;
            cpu_ack_reg <= cpu_ack_next;
            vid_ack_reg <= vid_ack_next;
            // Only the owner's read register is updated; the other holds.
            if (capture) begin
                if (owner_reg == REQ_VID) begin
                    vid_rdata_reg <= SRAM_RData;
                end else begin
                    cpu_rdata_reg <= SRAM_RData;
                end
            end
        end
    end

    assign CPU_RData    = cpu_rdata_reg;
    assign CPU_Ack      = cpu_ack_reg;
    assign VID_RData    = vid_rdata_reg;
    assign VID_Ack      = vid_ack_reg;
    assign Grant        = owner_reg;
    assign Busy         = (state_reg != IDLE);
    assign SRAM_ADDR    = {4'b0000, addr_reg};
    assign SRAM_CE_N    = ce_n_reg;
    assign SRAM_OE_N    = oe_n_reg;
    assign SRAM_WE_N    = we_n_reg;
    assign SRAM_LB_N    = lb_n_reg;
    assign SRAM_UB_N    = ub_n_reg;
    assign SRAM_WData   = wdata_reg;
    assign SRAM_DriveEn = drive_reg;

endmodule

// File: tb/tb_sram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_arbiter
// Self-checking bench for sram_arbiter: directed scenarios followed by
// randomized CPU/video traffic, checked against a transaction-level model
// (shadow memory, grant rule, fixed ack latencies) and a simple SRAM model.
// ---------------------------------------------------------------------------
module tb_sram_arbiter;

    localparam int AC = 2;
`ifdef ELC3_SRAM_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Reset_N;
    logic        CPU_Req, CPU_WE, VID_Req;
    logic [15:0] CPU_Addr, CPU_WData, VID_Addr;
    logic [15:0] CPU_RData, VID_RData;
    logic        CPU_Ack, VID_Ack, Grant, Busy;
    logic [19:0] SRAM_ADDR;
    logic        SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_LB_N, SRAM_UB_N;
    logic [15:0] SRAM_WData, SRAM_RData;
    logic        SRAM_DriveEn;

    always #5 Clk = ~Clk;

    sram_arbiter #(.ACCESS_CYCLES(AC)) dut (
        .Clk(Clk), .Reset_N(Reset_N),
        .CPU_Req(CPU_Req), .CPU_WE(CPU_WE), .CPU_Addr(CPU_Addr),
        .CPU_WData(CPU_WData), .CPU_RData(CPU_RData), .CPU_Ack(CPU_Ack),
        .VID_Req(VID_Req), .VID_Addr(VID_Addr), .VID_RData(VID_RData),
        .VID_Ack(VID_Ack), .Grant(Grant), .Busy(Busy),
        .SRAM_ADDR(SRAM_ADDR), .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N),
        .SRAM_WE_N(SRAM_WE_N), .SRAM_LB_N(SRAM_LB_N), .SRAM_UB_N(SRAM_UB_N),
        .SRAM_WData(SRAM_WData), .SRAM_DriveEn(SRAM_DriveEn),
        .SRAM_RData(SRAM_RData)
    );

    // SRAM device model and the bench's own expected memory contents.
    logic [15:0] mem    [0:65535];
    logic [15:0] shadow [0:65535];

    assign SRAM_RData = (!SRAM_CE_N && !SRAM_OE_N) ? mem[SRAM_ADDR[15:0]] : 16'h0000;

    always @(posedge Clk) begin
        if (!SRAM_CE_N && !SRAM_WE_N)
            mem[SRAM_ADDR[15:0]] <= SRAM_DriveEn ? SRAM_WData : 16'hDEAD;
    end

    // Pin monitor: running counters, sampled on the falling edge.
    int          oe_cnt = 0, we_cnt = 0, drv_cnt = 0;
    int          cpu_ack_cnt = 0, vid_ack_cnt = 0, viol_cnt = 0;
    logic [19:0] prev_addr = '0;
    logic [15:0] prev_wdata = '0;
    logic        prev_we_n = 1'b1;

    always @(negedge Clk) begin
        if (!Reset_N) begin
            prev_we_n = 1'b1;
        end else begin
            if (!SRAM_OE_N)    oe_cnt++;
            if (!SRAM_WE_N)    we_cnt++;
            if (SRAM_DriveEn)  drv_cnt++;
            if (CPU_Ack)       cpu_ack_cnt++;
            if (VID_Ack)       vid_ack_cnt++;
            if (CPU_Ack && VID_Ack) viol_cnt++;
            if (SRAM_ADDR[19:16] != 4'h0) viol_cnt++;
            if (SRAM_LB_N != SRAM_CE_N || SRAM_UB_N != SRAM_CE_N) viol_cnt++;
            if (!SRAM_WE_N && (SRAM_CE_N || !SRAM_DriveEn || !SRAM_OE_N)) viol_cnt++;
            // Address/data stable across the cycle before, during and after WE_N low.
            if ((!SRAM_WE_N || !prev_we_n) &&
                (SRAM_ADDR != prev_addr || SRAM_WData != prev_wdata || !SRAM_DriveEn))
                viol_cnt++;
            prev_we_n = SRAM_WE_N;
        end
        prev_addr  = SRAM_ADDR;
        prev_wdata = SRAM_WData;
    end

    int   checks = 0;
    int   errors = 0;
    int   txn_no = 0;
    logic last_owner = 1'b1;   // model of who won last (1 = video)

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wait_ack(input int limit, output int n, output logic [1:0] acks);
        n = 0;
        acks = 2'b00;
        while (n < limit) begin
            @(negedge Clk);
            n++;
            if (CPU_Ack || VID_Ack) begin
                acks = {CPU_Ack, VID_Ack};
                break;
            end
        end
    endtask

    task automatic check_txn(input string tag, input logic [1:0] acks, input logic is_vid,
                             input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                             input int n, input int exp_n);
        logic [15:0] rd;
        check_value({tag, "_lat"}, n, exp_n);
        check_value({tag, "_ack"}, acks, is_vid ? 2'b01 : 2'b10);
        check_value({tag, "_grant"}, Grant, is_vid);
        check_value({tag, "_busy"}, Busy, 1'b1);
        if (!we) begin
            rd = is_vid ? VID_RData : CPU_RData;
            check_value({tag, "_rdata"}, rd, shadow[addr]);
        end else begin
            shadow[addr] = wdata;
        end
        last_owner = is_vid;
        txn_no++;
        $display("txn %0d %s owner=%s we=%0d addr=%h data=%h lat=%0d", txn_no, tag,
                 is_vid ? "VID" : "CPU", we, addr, we ? wdata : shadow[addr], n);
    endtask

    // Issue up to one CPU and one video request together (called on a
    // falling edge in IDLE); each requester drops its request on its Ack.
    task automatic do_pair(input string tag, input logic cpu_en, input logic cpu_we,
                           input logic [15:0] cpu_addr, input logic [15:0] cpu_wdata,
                           input logic vid_en, input logic [15:0] vid_addr, input int gap);
        logic       first_vid;
        logic [1:0] acks;
        int         n;
        if (cpu_en && vid_en) first_vid = RR ? (last_owner == 1'b0) : 1'b0;
        else                  first_vid = vid_en;
        CPU_Req = cpu_en; CPU_WE = cpu_we; CPU_Addr = cpu_addr; CPU_WData = cpu_wdata;
        VID_Req = vid_en; VID_Addr = vid_addr;
        wait_ack(AC + 8, n, acks);
        check_txn({tag, "_a"}, acks, first_vid, first_vid ? 1'b0 : cpu_we,
                  first_vid ? vid_addr : cpu_addr, cpu_wdata, n, AC + 2);
        if (first_vid) VID_Req = 1'b0; else CPU_Req = 1'b0;
        if (cpu_en && vid_en) begin
            wait_ack(AC + 8, n, acks);
            check_txn({tag, "_b"}, acks, !first_vid, first_vid ? cpu_we : 1'b0,
                      first_vid ? cpu_addr : vid_addr, cpu_wdata, n, AC + 3);
            CPU_Req = 1'b0;
            VID_Req = 1'b0;
        end
        repeat (1 + gap) @(negedge Clk);
    endtask

    task automatic apply_reset();
        @(posedge Clk);
        #2;
        Reset_N = 1'b0;
        CPU_Req = 1'b0;
        VID_Req = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        Reset_N = 1'b1;
        last_owner = 1'b1;
        @(negedge Clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int          o0, w0, d0, v0, c0, x0, n;
        logic [1:0]  acks;
        logic        exp_vid;

        for (int i = 0; i < 65536; i++) begin
            mem[i]    = 16'(i * 7 + 3);
            shadow[i] = 16'(i * 7 + 3);
        end
        mem[16'h3000]    = 16'hBEEF;
        shadow[16'h3000] = 16'hBEEF;

        Reset_N = 1'b1;
        CPU_Req = 1'b0; CPU_WE = 1'b0; CPU_Addr = '0; CPU_WData = '0;
        VID_Req = 1'b0; VID_Addr = '0;
        #2 Reset_N = 1'b0;
        #1;
        check_value("rst_strobes", {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_LB_N, SRAM_UB_N}, 5'b11111);
        check_value("rst_drive", SRAM_DriveEn, 1'b0);
        check_value("rst_addr", SRAM_ADDR, 20'h0);
        check_value("rst_wdata", SRAM_WData, 16'h0);
        check_value("rst_rdata", {CPU_RData, VID_RData}, 32'h0);
        check_value("rst_ack_grant_busy", {CPU_Ack, VID_Ack, Grant, Busy}, 4'b0000);
        @(negedge Clk);
        @(negedge Clk);
        Reset_N = 1'b1;
        @(negedge Clk);

        // CPU read of 0x3000.
        o0 = oe_cnt; v0 = vid_ack_cnt;
        do_pair("cpu_rd", 1'b1, 1'b0, 16'h3000, 16'h0, 1'b0, 16'h0, 0);
        check_value("cpu_rd_oe_cycles", oe_cnt - o0, 3);
        check_value("cpu_rd_vid_ack", vid_ack_cnt - v0, 0);
        check_value("cpu_rd_beef", CPU_RData, 16'hBEEF);

        // CPU write 0xA5A5 to 0xFE00, then read it back.
        w0 = we_cnt; d0 = drv_cnt; o0 = oe_cnt; x0 = viol_cnt;
        do_pair("cpu_wr", 1'b1, 1'b1, 16'hFE00, 16'hA5A5, 1'b0, 16'h0, 0);
        check_value("cpu_wr_we_cycles", we_cnt - w0, 2);
        check_value("cpu_wr_drive_cycles", drv_cnt - d0, 4);
        check_value("cpu_wr_oe_cycles", oe_cnt - o0, 0);
        check_value("cpu_wr_addr", SRAM_ADDR, 20'h0FE00);
        check_value("cpu_wr_pin_rules", viol_cnt - x0, 0);
        do_pair("cpu_rb", 1'b1, 1'b0, 16'hFE00, 16'h0, 1'b0, 16'h0, 0);
        check_value("cpu_rb_a5a5", CPU_RData, 16'hA5A5);

        // Simultaneous, continuously held requests: four back-to-back grants.
        apply_reset();
        CPU_Req = 1'b1; CPU_WE = 1'b0; CPU_Addr = 16'h0200;
        VID_Req = 1'b1; VID_Addr = 16'h0300;
        v0 = vid_ack_cnt;
        for (int k = 0; k < 4; k++) begin
            exp_vid = RR ? (last_owner == 1'b0) : 1'b0;
            wait_ack(AC + 8, n, acks);
            check_txn($sformatf("tie%0d", k), acks, exp_vid, 1'b0,
                      exp_vid ? 16'h0300 : 16'h0200, 16'h0, n, (k == 0) ? AC + 2 : AC + 3);
        end
        CPU_Req = 1'b0;
        VID_Req = 1'b0;
        check_value("tie_vid_acks", vid_ack_cnt - v0, RR ? 2 : 0);
        @(negedge Clk);

        // Video read with a CPU request arriving during its ACCESS.
        VID_Req = 1'b1; VID_Addr = 16'h8000;
        @(negedge Clk);
        @(negedge Clk);
        CPU_Req = 1'b1; CPU_WE = 1'b0; CPU_Addr = 16'h3000;
        wait_ack(AC + 8, n, acks);
        check_txn("vid_first", acks, 1'b1, 1'b0, 16'h8000, 16'h0, n + 2, AC + 2);
        VID_Req = 1'b0;
        wait_ack(AC + 8, n, acks);
        check_txn("cpu_after", acks, 1'b0, 1'b0, 16'h3000, 16'h0, n, AC + 3);
        CPU_Req = 1'b0;
        @(negedge Clk);

        // Reset during the ACCESS phase of a write.
        CPU_Req = 1'b1; CPU_WE = 1'b1; CPU_Addr = 16'h0042; CPU_WData = 16'h1111;
        n = 0;
        while (SRAM_WE_N && n < AC + 8) begin
            @(negedge Clk);
            n++;
        end
        check_value("rst_mid_reached_access", SRAM_WE_N, 1'b0);
        c0 = cpu_ack_cnt; v0 = vid_ack_cnt;
        @(posedge Clk);
        #2;
        Reset_N = 1'b0;
        CPU_Req = 1'b0;
        #1;
        check_value("rst_mid_strobes", {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_LB_N, SRAM_UB_N}, 5'b11111);
        check_value("rst_mid_drive", SRAM_DriveEn, 1'b0);
        check_value("rst_mid_busy_ack", {Busy, CPU_Ack, VID_Ack}, 3'b000);
        @(negedge Clk);
        @(negedge Clk);
        Reset_N = 1'b1;
        last_owner = 1'b1;
        repeat (AC + 6) @(negedge Clk);
        check_value("rst_mid_no_ack", (cpu_ack_cnt - c0) + (vid_ack_cnt - v0), 0);
        check_value("rst_mid_idle", Busy, 1'b0);
        do_pair("post_rst", 1'b1, 1'b0, 16'h3000, 16'h0, 1'b0, 16'h0, 0);

        // CPU drops its request during SETUP of a read.
        c0 = cpu_ack_cnt;
        CPU_Req = 1'b1; CPU_WE = 1'b0; CPU_Addr = 16'h0123;
        @(negedge Clk);
        CPU_Req = 1'b0;
        wait_ack(AC + 8, n, acks);
        check_txn("drop_setup", acks, 1'b0, 1'b0, 16'h0123, 16'h0, n + 1, AC + 2);
        repeat (2 * (AC + 3)) @(negedge Clk);
        check_value("drop_setup_single_ack", cpu_ack_cnt - c0, 1);
        check_value("drop_setup_idle", Busy, 1'b0);

        // Randomized traffic on a small address window.
        for (int r = 0; r < 40; r++) begin
            int          mode;
            logic [15:0] ca, va;
            mode = $urandom_range(0, 2);
            ca = 16'h0100 + 16'($urandom_range(0, 31));
            va = 16'h0100 + 16'($urandom_range(0, 31));
            do_pair($sformatf("rnd%0d", r), mode != 1, 1'($urandom_range(0, 1)), ca,
                    16'($urandom), mode != 0, va, $urandom_range(0, 2));
        end
        check_value("pin_rules_total", viol_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
